// File: rtl/mmcm_reset_sequencer.sv
// MMCM reset / power-down sequencer: synchronizes LOCKED and the power-down request,
// retries on lock timeout, and recovers from lock loss. Define MMCM_SEQ_LOSS_COUNT_EN to count lock losses.
module mmcm_reset_sequencer #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       I_PWRDWN_REQ,
  input  logic       I_LOCKED,
  output logic       O_MMCM_RST,
  output logic       O_MMCM_PWRDWN,
  output logic       O_READY,
  output logic       O_FAIL,
  output logic [3:0] O_RETRIES,
  output logic [7:0] O_LOSS_CNT
);

  localparam int MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_L = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW    = $clog2(MAX_L);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PWRDWN, S_RESET, S_WAIT, S_STABLE, S_READY, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retries_q, retries_d, retries_inc;
  logic [1:0]    lock_sync_q, pd_sync_q;
  logic          lock_s, pd_s, fail_att;
  logic          mmcm_rst_q, pwrdwn_q, ready_q, fail_q;

  assign lock_s      = lock_sync_q[1];
  assign pd_s        = pd_sync_q[1];
  assign retries_inc = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_sync_q <= '0;
      pd_sync_q   <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], I_LOCKED};
      pd_sync_q   <= {pd_sync_q[0], I_PWRDWN_REQ};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    fail_att  = 1'b0;
    if (pd_s) begin
      state_d   = S_PWRDWN;
      retries_d = '0;
    end else begin
      case (state_q)
        S_PWRDWN: begin
          retries_d = '0;
          state_d   = S_RESET;
        end
        S_RESET: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RST_LAST) state_d = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          // Lock is tested first so it wins over a coincident timeout.
          if (lock_s)                 state_d  = S_STABLE;
          else if (cnt_q == TO_LAST)  fail_att = 1'b1;
        end
        S_STABLE: begin
          cnt_d = cnt_q + 1'b1;
          if (!lock_s) fail_att = 1'b1;
          else if (cnt_q == ST_LAST) begin
            state_d   = S_READY;
            retries_d = '0;
          end
        end
        S_READY: if (!lock_s) state_d = S_RESET;
        default: state_d = S_FAIL;
      endcase
      if (fail_att) begin
        retries_d = retries_inc;
        state_d   = (retries_inc >= RETRY_MAX) ? S_FAIL : S_RESET;
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      retries_q  <= '0;
      mmcm_rst_q <= 1'b1;
      pwrdwn_q   <= 1'b0;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      mmcm_rst_q <= (state_d == S_PWRDWN) || (state_d == S_RESET) || (state_d == S_FAIL);
      pwrdwn_q   <= (state_d == S_PWRDWN);
      ready_q    <= (state_d == S_READY);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  assign O_MMCM_RST    = mmcm_rst_q;
  assign O_MMCM_PWRDWN = pwrdwn_q;
  assign O_READY       = ready_q;
  assign O_FAIL        = fail_q;
  assign O_RETRIES     = retries_q;

`ifdef MMCM_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_q;
  logic       loss_inc;

  // Power-down on the same edge suppresses the count.
  assign loss_inc = (state_q == S_READY) && !lock_s && !pd_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            loss_q <= '0;
    else if (loss_inc && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign O_LOSS_CNT = loss_q;
`else
  assign O_LOSS_CNT = 8'd0;
`endif

endmodule
